mem_read_scheduler: RTL and testbench

- Shares one Avalon-MM read master (word reads, byteenable all ones) between two clients.
- Each client posts a job: start byte address plus word count. The block generates the sequential single-word reads, returns registered data with a valid strobe, and pulses done at the end of the job.
- Round-robin arbitration with a per-slice word limit, so neither client can starve the other.
- Sits between the ISP line-fetch logic and the DDR2 Avalon fabric.

---
 rtl/mem_read_pkg.sv | 15 +
 rtl/mem_read_job_ctx.sv | 60 ++++++
 rtl/mem_read_scheduler.sv | 199 +++++++++++++++++++
 tb/tb_mem_read_scheduler.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_read_pkg.sv
// Shared constants for the two-client Avalon-MM read scheduler.
package mem_read_pkg;

  localparam int unsigned STATE_W        = 2;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned DATA_W         = 32;

  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_GRANT = 2'd1;
  localparam logic [STATE_W-1:0] ST_READ  = 2'd2;

  localparam logic [3:0] BYTEENABLE_ALL = 4'b1111;

endpackage

// File: rtl/mem_read_job_ctx.sv
// Per-client job context: current word address, words remaining and busy flag.
module mem_read_job_ctx
  import mem_read_pkg::*;
#(
  parameter int unsigned LEN_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       start_addr,
  input  logic [LEN_W-1:0]  start_len,
  input  logic              advance,
  output logic              busy,
  output logic [31:0]       addr,
  output logic              last_c,
  output logic              zero_done_c
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic              busy_q, busy_d;
  logic              load_c;

  assign load_c      = start && !busy_q;
  assign zero_done_c = load_c && (start_len == '0);
  assign last_c      = busy_q && (remaining_q == LEN_W'(1));
  assign busy        = busy_q;
  assign addr        = addr_q;

  // A zero-length job never becomes busy; advance only applies to a live job.
  always_comb begin
    addr_d      = addr_q;
    remaining_d = remaining_q;
    busy_d      = busy_q;
    if (load_c && (start_len != '0)) begin
      addr_d      = start_addr;
      remaining_d = start_len;
      busy_d      = 1'b1;
    end else if (advance && busy_q) begin
      addr_d      = addr_q + ADDR_W'(BYTES_PER_WORD);
      remaining_d = remaining_q - LEN_W'(1);
      if (remaining_q == LEN_W'(1)) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_q      <= '0;
      remaining_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: rtl/mem_read_scheduler.sv
// Round-robin sharing of one Avalon-MM word-read master between two job-based clients.
module mem_read_scheduler
  import mem_read_pkg::*;
#(
  parameter int unsigned LEN_W = 16,
  parameter int unsigned SLICE = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c0_start,
  input  logic [31:0]       c0_addr,
  input  logic [LEN_W-1:0]  c0_len,
  output logic              c0_busy,
  output logic [31:0]       c0_data,
  output logic              c0_valid,
  output logic              c0_done,
  input  logic              c1_start,
  input  logic [31:0]       c1_addr,
  input  logic [LEN_W-1:0]  c1_len,
  output logic              c1_busy,
  output logic [31:0]       c1_data,
  output logic              c1_valid,
  output logic              c1_done,
  output logic [31:0]       master_address,
  output logic              master_read,
  output logic [3:0]        master_byteenable,
  input  logic [31:0]       master_readdata,
  input  logic              master_waitrequest
);

  logic [STATE_W-1:0] state_q, state_d;
  logic               owner_q, owner_d;
  logic               rr_q, rr_d;
  logic [LEN_W-1:0]   slice_q, slice_d;
  logic               read_q, read_d;
  logic [ADDR_W-1:0]  address_q, address_d;
  logic [DATA_W-1:0]  c0_data_q, c0_data_d, c1_data_q, c1_data_d;
  logic               c0_valid_q, c0_valid_d, c1_valid_q, c1_valid_d;
  logic               c0_done_q, c0_done_d, c1_done_q, c1_done_d;

  logic               adv0_c, adv1_c;
  logic               c0_last_c, c1_last_c, c0_zero_done_c, c1_zero_done_c;
  logic [ADDR_W-1:0]  c0_ctx_addr, c1_ctx_addr;
  logic               accept_c, own_last_c, other_busy_c;
  logic [ADDR_W-1:0]  own_addr_c;
  logic [LEN_W-1:0]   slice_next_c;

  mem_read_job_ctx #(.LEN_W(LEN_W)) u_ctx0 (
    .clk         (clk),
    .reset       (reset),
    .start       (c0_start),
    .start_addr  (c0_addr),
    .start_len   (c0_len),
    .advance     (adv0_c),
    .busy        (c0_busy),
    .addr        (c0_ctx_addr),
    .last_c      (c0_last_c),
    .zero_done_c (c0_zero_done_c)
  );

  mem_read_job_ctx #(.LEN_W(LEN_W)) u_ctx1 (
    .clk         (clk),
    .reset       (reset),
    .start       (c1_start),
    .start_addr  (c1_addr),
    .start_len   (c1_len),
    .advance     (adv1_c),
    .busy        (c1_busy),
    .addr        (c1_ctx_addr),
    .last_c      (c1_last_c),
    .zero_done_c (c1_zero_done_c)
  );

  assign accept_c     = read_q && !master_waitrequest;
  assign own_addr_c   = owner_q ? c1_ctx_addr : c0_ctx_addr;
  assign own_last_c   = owner_q ? c1_last_c : c0_last_c;
  assign other_busy_c = owner_q ? c0_busy : c1_busy;
  assign slice_next_c = slice_q + LEN_W'(1);

  // Next-state, bus request and return-path logic.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_d       = rr_q;
    slice_d    = slice_q;
    read_d     = read_q;
    address_d  = address_q;
    c0_data_d  = c0_data_q;
    c1_data_d  = c1_data_q;
    c0_valid_d = 1'b0;
    c1_valid_d = 1'b0;
    c0_done_d  = c0_zero_done_c;
    c1_done_d  = c1_zero_done_c;
    adv0_c     = 1'b0;
    adv1_c     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        read_d = 1'b0;
        if (c0_busy || c1_busy) begin
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        slice_d = '0;
        if (c0_busy && c1_busy) begin
          owner_d = rr_q;
          rr_d    = !rr_q;
        end else begin
          owner_d = c1_busy;
        end
        if (c0_busy || c1_busy) begin
          state_d   = ST_READ;
          read_d    = 1'b1;
          address_d = owner_d ? c1_ctx_addr : c0_ctx_addr;
        end else begin
          state_d = ST_IDLE;
          read_d  = 1'b0;
        end
      end
      ST_READ: begin
        if (accept_c) begin
          adv0_c = !owner_q;
          adv1_c = owner_q;
          if (owner_q) begin
            c1_data_d  = master_readdata;
            c1_valid_d = 1'b1;
            c1_done_d  = own_last_c;
          end else begin
            c0_data_d  = master_readdata;
            c0_valid_d = 1'b1;
            c0_done_d  = own_last_c;
          end
          // A full slice with nobody waiting restarts the count instead of re-arbitrating.
          if (own_last_c) begin
            state_d = ST_IDLE;
            read_d  = 1'b0;
          end else if (slice_next_c == LEN_W'(SLICE)) begin
            slice_d = '0;
            if (other_busy_c) begin
              state_d = ST_GRANT;
              read_d  = 1'b0;
            end else begin
              address_d = own_addr_c + ADDR_W'(BYTES_PER_WORD);
            end
          end else begin
            slice_d   = slice_next_c;
            address_d = own_addr_c + ADDR_W'(BYTES_PER_WORD);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        read_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      owner_q    <= 1'b0;
      rr_q       <= 1'b0;
      slice_q    <= '0;
      read_q     <= 1'b0;
      address_q  <= '0;
      c0_data_q  <= '0;
      c1_data_q  <= '0;
      c0_valid_q <= 1'b0;
      c1_valid_q <= 1'b0;
      c0_done_q  <= 1'b0;
      c1_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_q       <= rr_d;
      slice_q    <= slice_d;
      read_q     <= read_d;
      address_q  <= address_d;
      c0_data_q  <= c0_data_d;
      c1_data_q  <= c1_data_d;
      c0_valid_q <= c0_valid_d;
      c1_valid_q <= c1_valid_d;
      c0_done_q  <= c0_done_d;
      c1_done_q  <= c1_done_d;
    end
  end

  assign master_address    = address_q;
  assign master_read       = read_q;
  assign master_byteenable = BYTEENABLE_ALL;
  assign c0_data           = c0_data_q;
  assign c0_valid          = c0_valid_q;
  assign c0_done           = c0_done_q;
  assign c1_data           = c1_data_q;
  assign c1_valid          = c1_valid_q;
  assign c1_done           = c1_done_q;

endmodule

// File: tb/tb_mem_read_scheduler.sv
// Directed bench for mem_read_scheduler; memory returns the inverted word address.
module tb_mem_read_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        c0_start = 1'b0, c1_start = 1'b0;
  logic [31:0] c0_addr = '0, c1_addr = '0;
  logic [15:0] c0_len = '0, c1_len = '0;
  logic        c0_busy, c1_busy, c0_valid, c1_valid, c0_done, c1_done;
  logic [31:0] c0_data, c1_data;
  logic [31:0] master_address, master_readdata;
  logic        master_read;
  logic [3:0]  master_byteenable;
  logic        master_waitrequest = 1'b0;

  int errors = 0;
  int checks = 0;

  logic [31:0] acc_q[$];
  int          acc_cyc[$];
  logic [31:0] v0_q[$];
  logic [31:0] v1_q[$];
  int d0_cnt = 0, d1_cnt = 0, d0v_cnt = 0, stall_cnt = 0, stall_err = 0, cyc = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;

  int b_acc, b_v0, b_v1, b_d0, b_d1, b_d0v, b_stall;

  mem_read_scheduler #(.LEN_W(16), .SLICE(8)) dut (
    .clk               (clk),
    .reset             (reset),
    .c0_start          (c0_start),
    .c0_addr           (c0_addr),
    .c0_len            (c0_len),
    .c0_busy           (c0_busy),
    .c0_data           (c0_data),
    .c0_valid          (c0_valid),
    .c0_done           (c0_done),
    .c1_start          (c1_start),
    .c1_addr           (c1_addr),
    .c1_len            (c1_len),
    .c1_busy           (c1_busy),
    .c1_data           (c1_data),
    .c1_valid          (c1_valid),
    .c1_done           (c1_done),
    .master_address    (master_address),
    .master_read       (master_read),
    .master_byteenable (master_byteenable),
    .master_readdata   (master_readdata),
    .master_waitrequest(master_waitrequest)
  );

  always #5 clk = ~clk;
  assign master_readdata = ~master_address;

  // Bus and client-return monitor, sampled mid-cycle.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (prev_stall && reset && !(master_read && master_address == prev_addr)) stall_err = stall_err + 1;
    prev_stall = master_read && master_waitrequest;
    prev_addr  = master_address;
    if (master_read && master_waitrequest) stall_cnt = stall_cnt + 1;
    if (master_read && !master_waitrequest) begin
      acc_q.push_back(master_address);
      acc_cyc.push_back(cyc);
    end
    if (c0_valid) v0_q.push_back(c0_data);
    if (c1_valid) v1_q.push_back(c1_data);
    if (c0_done) d0_cnt = d0_cnt + 1;
    if (c1_done) d1_cnt = d1_cnt + 1;
    if (c0_done && c0_valid) d0v_cnt = d0v_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    b_acc = acc_q.size(); b_v0 = v0_q.size(); b_v1 = v1_q.size();
    b_d0 = d0_cnt; b_d1 = d1_cnt; b_d0v = d0v_cnt; b_stall = stall_cnt;
  endtask

  task automatic start_job(input bit which, input logic [31:0] a, input logic [15:0] l);
    if (!which) begin c0_start = 1'b1; c0_addr = a; c0_len = l; end
    else begin c1_start = 1'b1; c1_addr = a; c1_len = l; end
    tick();
    c0_start = 1'b0;
    c1_start = 1'b0;
  endtask

  task automatic wait_read(input string tag);
    for (int i = 0; i < 20 && !master_read; i++) tick();
    check(tag, 32'(master_read), 32'd1);
  endtask

  initial begin
    logic [31:0] e0, e1, exp_a;
    int seg_cli[6];
    int seg_len[6];
    int k;

    // Reset state
    repeat (3) tick();
    check("rst_read", 32'(master_read), 32'd0);
    check("rst_addr", master_address, 32'd0);
    check("rst_be", 32'(master_byteenable), 32'hF);
    check("rst_busy", {30'd0, c1_busy, c0_busy}, 32'd0);
    check("rst_valid", {30'd0, c1_valid, c0_valid}, 32'd0);
    check("rst_done", {30'd0, c1_done, c0_done}, 32'd0);
    reset = 1'b1;
    tick();

    // Single four-word job
    snap();
    start_job(1'b0, 32'h1000, 16'd4);
    check("single_busy", 32'(c0_busy), 32'd1);
    repeat (15) tick();
    check("single_nacc", 32'(acc_q.size() - b_acc), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("single_addr", acc_q[b_acc + i], 32'h1000 + 32'(4 * i));
      check("single_data", v0_q[b_v0 + i], ~(32'h1000 + 32'(4 * i)));
    end
    check("single_b2b", 32'(acc_cyc[b_acc + 3] - acc_cyc[b_acc]), 32'd3);
    check("single_nv0", 32'(v0_q.size() - b_v0), 32'd4);
    check("single_done", 32'(d0_cnt - b_d0), 32'd1);
    check("single_done_w_valid", 32'(d0v_cnt - b_d0v), 32'd1);
    check("single_nv1", 32'(v1_q.size() - b_v1), 32'd0);
    check("single_idle_busy", 32'(c0_busy), 32'd0);

    // Waitrequest stall on the first read
    snap();
    master_waitrequest = 1'b1;
    start_job(1'b0, 32'h2000, 16'd2);
    wait_read("stall_read_seen");
    repeat (3) tick();
    master_waitrequest = 1'b0;
    repeat (10) tick();
    check("stall_cycles", 32'(stall_cnt - b_stall), 32'd3);
    check("stall_stable", 32'(stall_err), 32'd0);
    check("stall_nv0", 32'(v0_q.size() - b_v0), 32'd2);
    check("stall_d0", v0_q[b_v0], ~32'h2000);
    check("stall_d1", v0_q[b_v0 + 1], ~32'h2004);
    check("stall_done", 32'(d0_cnt - b_d0), 32'd1);

    // Fairness: two 20-word jobs started together
    snap();
    c1_start = 1'b1; c1_addr = 32'h0002_0000; c1_len = 16'd20;
    start_job(1'b0, 32'h0001_0000, 16'd20);
    repeat (80) tick();
    seg_cli = '{0, 1, 0, 1, 0, 1};
    seg_len = '{8, 8, 8, 8, 4, 4};
    e0 = 32'h0001_0000;
    e1 = 32'h0002_0000;
    k = b_acc;
    check("fair_nacc", 32'(acc_q.size() - b_acc), 32'd40);
    if (acc_q.size() - b_acc == 40) begin
      for (int s = 0; s < 6; s++) begin
        for (int j = 0; j < seg_len[s]; j++) begin
          if (seg_cli[s] == 0) begin exp_a = e0; e0 = e0 + 32'd4; end
          else begin exp_a = e1; e1 = e1 + 32'd4; end
          check("fair_addr", acc_q[k], exp_a);
          k = k + 1;
        end
      end
    end
    check("fair_nv0", 32'(v0_q.size() - b_v0), 32'd20);
    check("fair_nv1", 32'(v1_q.size() - b_v1), 32'd20);
    if (v0_q.size() - b_v0 == 20 && v1_q.size() - b_v1 == 20) begin
      for (int i = 0; i < 20; i++) begin
        check("fair_d0", v0_q[b_v0 + i], ~(32'h0001_0000 + 32'(4 * i)));
        check("fair_d1", v1_q[b_v1 + i], ~(32'h0002_0000 + 32'(4 * i)));
      end
    end
    check("fair_done0", 32'(d0_cnt - b_d0), 32'd1);
    check("fair_done1", 32'(d1_cnt - b_d1), 32'd1);

    // Zero-length job on client 1
    snap();
    start_job(1'b1, 32'h3000, 16'd0);
    check("zero_done_next", 32'(c1_done), 32'd1);
    check("zero_busy", 32'(c1_busy), 32'd0);
    repeat (6) tick();
    check("zero_noread", 32'(acc_q.size() - b_acc), 32'd0);
    check("zero_done_cnt", 32'(d1_cnt - b_d1), 32'd1);
    check("zero_nv1", 32'(v1_q.size() - b_v1), 32'd0);

    // Start while busy is ignored
    snap();
    start_job(1'b0, 32'h4000, 16'd3);
    start_job(1'b0, 32'h5000, 16'd5);
    repeat (15) tick();
    check("ign_nacc", 32'(acc_q.size() - b_acc), 32'd3);
    check("ign_a0", acc_q[b_acc], 32'h4000);
    check("ign_a2", acc_q[b_acc + 2], 32'h4008);
    check("ign_done", 32'(d0_cnt - b_d0), 32'd1);

    // Address wrap at 2^32
    snap();
    start_job(1'b0, 32'hFFFF_FFFC, 16'd2);
    repeat (10) tick();
    check("wrap_nacc", 32'(acc_q.size() - b_acc), 32'd2);
    check("wrap_a0", acc_q[b_acc], 32'hFFFF_FFFC);
    check("wrap_a1", acc_q[b_acc + 1], 32'h0000_0000);
    check("wrap_d1", v0_q[b_v0 + 1], 32'hFFFF_FFFF);

    // Reset in the middle of a stalled read
    master_waitrequest = 1'b1;
    start_job(1'b0, 32'h6000, 16'd4);
    wait_read("mid_read_seen");
    reset = 1'b0;
    tick();
    check("mid_rst_read", 32'(master_read), 32'd0);
    check("mid_rst_busy", {30'd0, c1_busy, c0_busy}, 32'd0);
    check("mid_rst_vd", {28'd0, c1_valid, c0_valid, c1_done, c0_done}, 32'd0);
    reset = 1'b1;
    master_waitrequest = 1'b0;
    tick();
    snap();
    start_job(1'b0, 32'h7000, 16'd2);
    repeat (10) tick();
    check("post_rst_nacc", 32'(acc_q.size() - b_acc), 32'd2);
    check("post_rst_a0", acc_q[b_acc], 32'h7000);
    check("post_rst_a1", acc_q[b_acc + 1], 32'h7004);
    check("post_rst_done", 32'(d0_cnt - b_d0), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
